// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Brief    : Shared constants and FSM state type for the Ethernet RX frame store
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int ETH_BUF_DEPTH = 2048;
    localparam int ETH_ADDR_W    = 11;
    localparam int ETH_LEN_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_READY = 2'd2,
        ST_DROP  = 2'd3
    } eth_rx_state_t;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : eth_sync_edge
// Brief    : 2-flop synchroniser plus history flop with rise/fall detection
// Revision : 1.0 - initial release
// ============================================================================
module eth_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            hist <= RESET_VAL;
        end else begin
            meta <= async_in;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule : eth_sync_edge
`default_nettype wire

// File: rtl/eth_rx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_buf
// Brief    : Clock-domain bridge and 2048-byte frame store for the SPI receiver
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_frame_buf
    import eth_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  ena,
    input  logic [7:0]            recv_d,
    input  logic                  n_recv_buf_we,
    input  logic [ETH_ADDR_W-1:0] cpu_addr,
    output logic [7:0]            cpu_rd_data,
    input  logic                  cpu_ack,
    output logic                  rx_ready,
    output logic [ETH_LEN_W-1:0]  rx_len,
    output logic                  rx_trunc,
    output logic [7:0]            drop_cnt
);

    logic ena_level;
    logic ena_rise;
    logic ena_fall;
    logic byte_stb;
    logic unused_we_level;
    logic unused_we_rise;

    eth_sync_edge #(.RESET_VAL(1'b0)) u_ena_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (ena),
        .level    (ena_level),
        .rise     (ena_rise),
        .fall     (ena_fall)
    );

    eth_sync_edge #(.RESET_VAL(1'b1)) u_we_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (n_recv_buf_we),
        .level    (unused_we_level),
        .rise     (unused_we_rise),
        .fall     (byte_stb)
    );

    // The ena sync flops reset low, so a frame already active at reset release
    // would look like a rise. Only accept rises once ena has been seen low.
    logic [1:0] settle;
    logic       armed;
    logic       ena_start;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & ~ena_level);
        end
    end

    assign ena_start = ena_rise & armed;

    eth_rx_state_t        state;
    logic [ETH_LEN_W-1:0] wptr;
    logic                 ack_seen;
    logic                 mem_we;

    assign mem_we = (state == ST_RECV) && byte_stb && !wptr[ETH_ADDR_W];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            rx_ready <= 1'b0;
            rx_len   <= '0;
            rx_trunc <= 1'b0;
            drop_cnt <= '0;
            ack_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ena_start) begin
                        state    <= ST_RECV;
                        wptr     <= '0;
                        rx_trunc <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (byte_stb) begin
                        if (!wptr[ETH_ADDR_W])
                            wptr <= wptr + ETH_LEN_W'(1);
                        else
                            rx_trunc <= 1'b1;
                    end
                    if (ena_fall) begin
                        if (wptr == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_READY;
                            rx_len   <= wptr;
                            rx_ready <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    // Release takes priority over a simultaneous new frame.
                    if (cpu_ack) begin
                        rx_ready <= 1'b0;
                        if (ena_start) begin
                            state    <= ST_RECV;
                            wptr     <= '0;
                            rx_trunc <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (ena_start) begin
                        state    <= ST_DROP;
                        ack_seen <= 1'b0;
                        if (drop_cnt != 8'hFF)
                            drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                ST_DROP: begin
                    if (cpu_ack) begin
                        rx_ready <= 1'b0;
                        ack_seen <= 1'b1;
                    end
                    if (ena_fall)
                        state <= (ack_seen || cpu_ack) ? ST_IDLE : ST_READY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [7:0] mem [ETH_BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr[ETH_ADDR_W-1:0]] <= recv_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cpu_rd_data <= 8'h00;
        else
            cpu_rd_data <= mem[cpu_addr];
    end

endmodule : eth_rx_frame_buf
`default_nettype wire

// File: tb/tb_eth_rx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_frame_buf
// Brief    : Directed self-checking bench for eth_rx_frame_buf
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_buf;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        ena = 1'b0;
    logic [7:0]  recv_d = 8'h00;
    logic        n_recv_buf_we = 1'b1;
    logic [10:0] cpu_addr = 11'd0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_ack = 1'b0;
    logic        rx_ready;
    logic [11:0] rx_len;
    logic        rx_trunc;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    eth_rx_frame_buf dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .ena           (ena),
        .recv_d        (recv_d),
        .n_recv_buf_we (n_recv_buf_we),
        .cpu_addr      (cpu_addr),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_ack       (cpu_ack),
        .rx_ready      (rx_ready),
        .rx_len        (rx_len),
        .rx_trunc      (rx_trunc),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // sck = 8 clk: 4 periods low, 4 periods high
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        recv_d = b;
        n_recv_buf_we = 1'b0;
        repeat (4) @(posedge clk);
        #2 n_recv_buf_we = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic open_frame();
        @(posedge clk); #2 ena = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic close_frame();
        @(posedge clk); #2 ena = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        @(posedge clk); #2 cpu_addr = a;
        @(posedge clk); #1 d = cpu_rd_data;
    endtask

    task automatic ack_pulse();
        @(posedge clk); #2 cpu_ack = 1'b1;
        @(posedge clk); #2 cpu_ack = 1'b0;
    endtask

    function automatic logic [7:0] big_byte(input int i);
        logic [11:0] v;
        v = 12'(i);
        return v[7:0] ^ v[11:4];
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if ({cpu_rd_data, rx_ready, rx_len, rx_trunc, drop_cnt} !== 30'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rd=%h rdy=%b len=%0d trunc=%b drop=%0d, want all 0",
                     cpu_rd_data, rx_ready, rx_len, rx_trunc, drop_cnt);
        end
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] d;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h55; exp_b[1] = 8'hAA; exp_b[2] = 8'h01;
        open_frame();
        for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
        @(posedge clk); #2 ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_ready_early: got %b, want 0 after 2 edges", rx_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_ready_3edges: got %b, want 1", rx_ready);
        end
        tests++;
        if (rx_len !== 12'd3 || rx_trunc !== 1'b0) begin
            fails++;
            $display("FAIL basic_len: got len=%0d trunc=%b, want 3/0", rx_len, rx_trunc);
        end
        for (int i = 0; i < 3; i++) begin
            rd(11'(i), d);
            tests++;
            if (d !== exp_b[i]) begin
                fails++;
                $display("FAIL basic_data[%0d]: got %h, want %h", i, d, exp_b[i]);
            end
        end
        ack_pulse();
        #1;
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_ack: rx_ready got %b, want 0", rx_ready);
        end
    endtask

    task automatic test_truncation();
        logic [7:0] d;
        open_frame();
        for (int i = 0; i < 2050; i++) send_byte(big_byte(i));
        close_frame();
        #1;
        tests++;
        if (rx_ready !== 1'b1 || rx_len !== 12'd2048 || rx_trunc !== 1'b1) begin
            fails++;
            $display("FAIL trunc_status: got rdy=%b len=%0d trunc=%b, want 1/2048/1",
                     rx_ready, rx_len, rx_trunc);
        end
        rd(11'd2047, d);
        tests++;
        if (d !== 8'h80) begin
            fails++;
            $display("FAIL trunc_mem2047: got %h, want 80", d);
        end
        rd(11'd0, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL trunc_mem0: got %h, want 00", d);
        end
        rd(11'd1, d);
        tests++;
        if (d !== 8'h01) begin
            fails++;
            $display("FAIL trunc_mem1: got %h, want 01", d);
        end
        rd(11'd1000, d);
        tests++;
        if (d !== 8'hD6) begin
            fails++;
            $display("FAIL trunc_mem1000: got %h, want d6", d);
        end
        ack_pulse();
    endtask

    task automatic test_drop();
        logic [7:0] d;
        open_frame();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        close_frame();
        open_frame();
        for (int i = 0; i < 10; i++) send_byte(8'hE0 + 8'(i));
        close_frame();
        #1;
        tests++;
        if (drop_cnt !== 8'd1 || rx_ready !== 1'b1 || rx_len !== 12'd4 || rx_trunc !== 1'b0) begin
            fails++;
            $display("FAIL drop_status: got drop=%0d rdy=%b len=%0d trunc=%b, want 1/1/4/0",
                     drop_cnt, rx_ready, rx_len, rx_trunc);
        end
        rd(11'd0, d);
        tests++;
        if (d !== 8'h11) begin
            fails++;
            $display("FAIL drop_data0: got %h, want 11", d);
        end
        rd(11'd3, d);
        tests++;
        if (d !== 8'h44) begin
            fails++;
            $display("FAIL drop_data3: got %h, want 44", d);
        end
    endtask

    task automatic test_ack_with_rise();
        logic [7:0] d;
        @(posedge clk); #2 ena = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 cpu_ack = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL ackrise_clear: rx_ready got %b, want 0", rx_ready);
        end
        #1 cpu_ack = 1'b0;
        repeat (2) @(posedge clk);
        send_byte(8'hC3); send_byte(8'h3C);
        close_frame();
        #1;
        tests++;
        if (rx_ready !== 1'b1 || rx_len !== 12'd2 || drop_cnt !== 8'd1) begin
            fails++;
            $display("FAIL ackrise_status: got rdy=%b len=%0d drop=%0d, want 1/2/1",
                     rx_ready, rx_len, drop_cnt);
        end
        rd(11'd1, d);
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL ackrise_data1: got %h, want 3c", d);
        end
        ack_pulse();
    endtask

    task automatic test_empty_frame();
        open_frame();
        close_frame();
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (rx_ready !== 1'b0 || rx_len !== 12'd2) begin
            fails++;
            $display("FAIL empty_frame: got rdy=%b len=%0d, want 0/2", rx_ready, rx_len);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
        open_frame();
        for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i));
        @(posedge clk); #3 n_rst = 1'b0;
        #1;
        tests++;
        if ({cpu_rd_data, rx_ready, rx_len, rx_trunc, drop_cnt} !== 30'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got rd=%h rdy=%b len=%0d trunc=%b drop=%0d, want all 0",
                     cpu_rd_data, rx_ready, rx_len, rx_trunc, drop_cnt);
        end
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i));
        close_frame();
        #1;
        tests++;
        if (rx_ready !== 1'b0 || rx_len !== 12'd0) begin
            fails++;
            $display("FAIL midreset_ignored: got rdy=%b len=%0d, want 0/0", rx_ready, rx_len);
        end
        open_frame();
        for (int i = 0; i < 4; i++) send_byte(exp_b[i]);
        close_frame();
        #1;
        tests++;
        if (rx_ready !== 1'b1 || rx_len !== 12'd4) begin
            fails++;
            $display("FAIL midreset_next: got rdy=%b len=%0d, want 1/4", rx_ready, rx_len);
        end
        rd(11'd2, d);
        tests++;
        if (d !== 8'hC3) begin
            fails++;
            $display("FAIL midreset_data2: got %h, want c3", d);
        end
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #2 ena = 1'b1;
            repeat (4) @(posedge clk);
            #2 ena = 1'b0;
            repeat (4) @(posedge clk);
            if (i == 0) begin
                #1;
                tests++;
                if (drop_cnt !== 8'd1) begin
                    fails++;
                    $display("FAIL sat_first: drop_cnt got %0d, want 1", drop_cnt);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (drop_cnt !== 8'd255 || rx_ready !== 1'b1 || rx_len !== 12'd4) begin
            fails++;
            $display("FAIL sat_final: got drop=%0d rdy=%b len=%0d, want 255/1/4",
                     drop_cnt, rx_ready, rx_len);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_truncation();
        test_drop();
        test_ack_with_rise();
        test_empty_frame();
        test_reset_mid_frame();
        test_drop_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_eth_rx_frame_buf
`default_nettype wire

// File: doc/eth_rx_frame_buf.md
# eth_rx_frame_buf

Clock-domain bridge and frame store sitting directly downstream of the Ethernet SPI receiver. Synchronises the receiver's asynchronous byte-write strobe and frame-enable into the CPU clock domain. Captures each completed byte into an internal 2048-byte buffer and latches frame length on frame end. Presents the stored frame to the CPU through a random-access read port, with a ready/ack handshake and a drop counter for frames arriving while the buffer is occupied.

## Interface
- Parameters: none (depth fixed at 2048 bytes, address 11 bits).
- `clk` in 1: CPU clock; all state changes on rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `ena` in 1: frame-active from the SPI side; asynchronous to `clk`; rising edge starts a frame, falling edge ends it.
- `recv_d` in 8: received byte (MSB-first already reordered by the receiver); asynchronous; stable for one full sck period after `n_recv_buf_we` falls.
- `n_recv_buf_we` in 1: active-low byte-complete strobe; asynchronous; its falling edge marks one new byte.
- `cpu_addr` in 11: read address into the buffer.
- `cpu_rd_data` out 8: `mem[cpu_addr]`, registered, one-cycle read latency.
- `cpu_ack` in 1: single-cycle pulse; CPU releases the buffer.
- `rx_ready` out 1: a complete frame is held.
- `rx_len` out 12: byte count of held frame, 1..2048.
- `rx_trunc` out 1: held frame exceeded 2048 bytes; extra bytes discarded.
- `drop_cnt` out 8: frames dropped while buffer busy; saturates at 255.

## Operation
- `ena` and `n_recv_buf_we` each pass through a 2-flop synchroniser plus one history flop. `ena_rise`, `ena_fall` and `byte_stb` are derived from them, where `byte_stb` is the falling edge of the synchronised `n_recv_buf_we`.
- `recv_d` is sampled directly (no synchroniser) in the cycle `byte_stb` is true. Validity is guaranteed by the stability window.
- FSM states: IDLE, RECV, READY, DROP.
- IDLE:
  - `ena_rise` -> RECV; wptr=0, `rx_trunc`=0.
- RECV:
  - `byte_stb` with wptr<2048 -> write `mem[wptr]`=`recv_d`, wptr++.
  - `byte_stb` with wptr==2048 -> no write, `rx_trunc`=1.
  - `ena_fall` with wptr==0 -> IDLE (empty frame silently discarded).
  - `ena_fall` with wptr>0 -> READY; `rx_len`=wptr, `rx_ready`=1.
- READY:
  - `cpu_ack` -> IDLE, `rx_ready`=0.
  - `ena_rise` without `cpu_ack` -> DROP, `drop_cnt`++ (saturating).
  - `ena_rise` together with `cpu_ack` -> ack wins; go to RECV directly, frame accepted.
- DROP:
  - Buffer, `rx_len` and `rx_trunc` unchanged; `byte_stb` ignored.
  - `ena_fall` -> READY, or IDLE if `cpu_ack` was seen during DROP.
  - `cpu_ack` in DROP clears `rx_ready` immediately.
- `byte_stb` outside RECV is ignored. `cpu_ack` outside READY/DROP is ignored.
- `rx_len` and `rx_trunc` hold their values until the next frame enters RECV.
- CPU reads are legal in any state. Contents are defined only while `rx_ready`=1.
- Reset (any time, including mid-frame) gives:
  - state IDLE, wptr 0, `rx_ready` 0, `rx_len` 0, `rx_trunc` 0, `drop_cnt` 0, `cpu_rd_data` 0, all sync flops 0/idle (`n_recv_buf_we` sync flops reset to 1).
  - Buffer contents are not cleared.
  - A frame in progress when reset releases is entered only on the next `ena_rise`.

## Timing
- Input change to action:
  - 3rd `clk` rising edge after an input edge meets setup at flop 1.
  - 4th edge if it misses setup.
- Write to `mem` and wptr increment happen on that edge.
- `rx_ready` is high after the edge processing `ena_fall` (3 edges after `ena` falls).
- `cpu_rd_data` is valid on the edge after `cpu_addr` is presented. A byte written at edge N is readable with address applied at N.
- Source constraints:
  - sck high and low phases ≥3 `clk` periods each.
  - Last `n_recv_buf_we` rise precedes `ena` fall by ≥2 `clk` periods.
  - `ena` low time between frames ≥3 `clk` periods.

## Structure
- Shared package `eth_pkg`:
  - `ETH_BUF_DEPTH`=2048, `ETH_ADDR_W`=11, `ETH_LEN_W`=12.
  - FSM state enum `eth_rx_state_t`.
- One sub-module `eth_sync_edge` (2-flop sync + history flop, reset value as parameter, rise/fall outputs), instantiated twice.
- Buffer is an inferred synchronous single-write/single-read RAM inside the block.

## Test plan
- Reset, then a 3-byte frame 0x55,0xAA,0x01 with sck = 8 `clk` -> `rx_ready`=1 3 edges after `ena` falls; `rx_len`=3; reads at 0..2 return 0x55,0xAA,0x01; `rx_trunc`=0.
- Frame of 2050 bytes -> `rx_len`=2048, `rx_trunc`=1, `mem[2047]`=byte 2047.
- Frame held, second frame of 10 bytes arrives before ack -> `drop_cnt`=1; original `rx_len` and data intact; after `ena` falls, `rx_ready` still 1.
- `cpu_ack` on the same edge as a synchronised `ena_rise` in READY -> new frame captured; `rx_ready` reasserts with the new length; `drop_cnt` unchanged.
- `ena` pulse with no bytes -> state returns to IDLE; `rx_ready` stays 0.
- `n_rst` asserted mid-frame after 5 bytes -> all outputs 0 asynchronously. Remainder of that frame is ignored after release; the next full frame is captured normally. 256 dropped frames -> `drop_cnt`=255.
